// File: rtl/sid_audio_i2s.sv
// SID mixer output path: box-filter decimation of the 1 MHz offset-binary stream,
// a 4-deep sample FIFO, and a standard-I2S serializer sending the same word on both channels.
module sid_audio_i2s #(
   parameter int DECIM_LOG2 = 5,
   parameter int BCLK_DIV   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce_1m,
   input  logic [17:0] audio_in,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   output logic        i2s_bclk,
   output logic        i2s_lrck,
   output logic        i2s_sdata,
   output logic        overflow,
   output logic        underflow
);
   localparam int AW = 18 + DECIM_LOG2;

   logic [AW-1:0]         acc_q, acc_d, sum, sample_ext;
   logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
   logic [15:0]           sample_q, sample_d;
   logic                  valid_q, valid_d;

   logic [15:0] fifo_q [4];
   logic [15:0] fifo_d [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic        ovf_q, ovf_d, unf_q, unf_d;
   logic        do_push, pop;

   logic [7:0]  div_q, div_d;
   logic        bclk_q, bclk_d;
   logic [5:0]  bit_q, bit_d;
   logic        lrck_q, lrck_d, sdata_q, sdata_d;
   logic [15:0] hold_q, hold_d;
   logic        tick, fall, frame_end;
   logic [4:0]  pos;
   logic [3:0]  idx;

   // Offset binary -> two's complement is a flip of the MSB, then sign-extend.
   always_comb begin
      sample_ext = {{DECIM_LOG2{~audio_in[17]}}, ~audio_in[17], audio_in[16:0]};
      sum        = acc_q + sample_ext;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      valid_d    = 1'b0;
      sample_d   = sample_q;
      if (ce_1m) begin
         cnt_d = cnt_q + DECIM_LOG2'(1);
         if (&cnt_q) begin
            acc_d    = '0;
            valid_d  = 1'b1;
            sample_d = sum[AW-1 -: 16];
         end else begin
            acc_d = sum;
         end
      end
   end

   // sample_valid is a one-clk strobe with no back-pressure: the FIFO takes it or drops it.
   always_comb begin
      tick      = (div_q == 8'(BCLK_DIV - 1));
      div_d     = tick ? 8'd0 : div_q + 8'd1;
      bclk_d    = tick ? ~bclk_q : bclk_q;
      fall      = tick & bclk_q;
      frame_end = fall & (bit_q == 6'd63);
      bit_d     = fall ? bit_q + 6'd1 : bit_q;

      pop      = frame_end && (count_q != 3'd0);
      do_push  = valid_q && ((count_q != 3'd4) || pop);
      ovf_d    = ovf_q | (valid_q & ~do_push);
      unf_d    = unf_q | (frame_end && (count_q == 3'd0));
      hold_d   = pop ? fifo_q[rd_ptr_q] : hold_q;
      rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
      wr_ptr_d = do_push ? wr_ptr_q + 2'd1 : wr_ptr_q;
      fifo_d   = fifo_q;
      if (do_push) fifo_d[wr_ptr_q] = sample_q;
      case ({do_push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase

      // Slot 0 of each half carries the lrck transition; data occupies slots 1..16.
      pos     = bit_d[4:0];
      idx     = pos[3:0] - 4'd1;
      lrck_d  = fall ? bit_d[5] : lrck_q;
      sdata_d = sdata_q;
      if (fall) sdata_d = (pos >= 5'd1 && pos <= 5'd16) ? hold_q[~idx] : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         fifo_q   <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         div_q    <= '0;
         bclk_q   <= 1'b0;
         bit_q    <= '0;
         lrck_q   <= 1'b0;
         sdata_q  <= 1'b0;
         hold_q   <= '0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         fifo_q   <= fifo_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         div_q    <= div_d;
         bclk_q   <= bclk_d;
         bit_q    <= bit_d;
         lrck_q   <= lrck_d;
         sdata_q  <= sdata_d;
         hold_q   <= hold_d;
      end
   end

   assign sample_out   = sample_q;
   assign sample_valid = valid_q;
   assign i2s_bclk     = bclk_q;
   assign i2s_lrck     = lrck_q;
   assign i2s_sdata    = sdata_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;
endmodule

// File: tb/tb_sid_audio_i2s.sv
// Bench for sid_audio_i2s: decimation, FIFO and I2S framing against an event-level reference model.
module tb_sid_audio_i2s;
   localparam int D     = 5;
   localparam int BD    = 2;
   localparam int FRAME = 128 * BD;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce_1m = 1'b0;
   logic [17:0] audio_in = '0;
   logic [15:0] sample_out, sample_out_b;
   logic        sample_valid, i2s_bclk, i2s_lrck, i2s_sdata, overflow, underflow;
   logic        sample_valid_b, i2s_bclk_b, i2s_lrck_b, i2s_sdata_b, overflow_b, underflow_b;

   always #5 clk = ~clk;

   sid_audio_i2s #(.DECIM_LOG2(D), .BCLK_DIV(BD)) dut (
      .clk(clk), .reset(reset), .ce_1m(ce_1m), .audio_in(audio_in),
      .sample_out(sample_out), .sample_valid(sample_valid), .i2s_bclk(i2s_bclk),
      .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata), .overflow(overflow), .underflow(underflow));

   sid_audio_i2s #(.DECIM_LOG2(1), .BCLK_DIV(255)) dut_b (
      .clk(clk), .reset(reset), .ce_1m(ce_1m), .audio_in(audio_in),
      .sample_out(sample_out_b), .sample_valid(sample_valid_b), .i2s_bclk(i2s_bclk_b),
      .i2s_lrck(i2s_lrck_b), .i2s_sdata(i2s_sdata_b), .overflow(overflow_b), .underflow(underflow_b));

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: mean of each block of 2^D samples, a queue FIFO, one pop per frame end.
   int          m_t, m_cnt, m_sum;
   logic        m_valid, m_ovf, m_unf;
   logic [15:0] m_sample, m_hold;
   logic [15:0] m_fifo[$];
   logic [15:0] exp_q[$];

   function automatic void model_step();
      if (reset) begin
         m_t = 0; m_cnt = 0; m_sum = 0; m_valid = 1'b0; m_sample = '0; m_hold = '0;
         m_ovf = 1'b0; m_unf = 1'b0;
         m_fifo.delete(); exp_q.delete(); exp_q.push_back(16'h0000);
      end else begin
         m_t++;
         if (m_t % FRAME == 0) begin
            if (m_fifo.size() > 0) m_hold = m_fifo.pop_front();
            else m_unf = 1'b1;
            exp_q.push_back(m_hold);
         end
         if (m_valid) begin
            if (m_fifo.size() < 4) m_fifo.push_back(m_sample);
            else m_ovf = 1'b1;
         end
         m_valid = 1'b0;
         if (ce_1m) begin
            m_sum += int'(audio_in) - 131072;
            m_cnt++;
            if (m_cnt == (1 << D)) begin
               m_valid = 1'b1; m_sample = 16'(m_sum >>> (D + 2)); m_sum = 0; m_cnt = 0;
            end
         end
      end
   endfunction

   // Serial monitor: {lrck, sdata} captured on every bclk rise, plus timing-rule counters.
   logic [1:0] got_q[$];
   int         mon_cyc, bclk_bad, sd_bad;
   logic       mon_bclk, mon_sd, mon_lr;

   function automatic void mon_step();
      if (reset) begin
         got_q.delete(); mon_cyc = 0; bclk_bad = 0; sd_bad = 0;
         mon_bclk = 1'b0; mon_sd = 1'b0; mon_lr = 1'b0;
      end else begin
         mon_cyc++;
         if (i2s_bclk !== mon_bclk) begin
            if (mon_cyc != BD) bclk_bad++;
            mon_cyc = 0;
         end
         if ((i2s_sdata !== mon_sd || i2s_lrck !== mon_lr) && !(mon_bclk === 1'b1 && i2s_bclk === 1'b0))
            sd_bad++;
         if (mon_bclk === 1'b0 && i2s_bclk === 1'b1) got_q.push_back({i2s_lrck, i2s_sdata});
         mon_bclk = i2s_bclk; mon_sd = i2s_sdata; mon_lr = i2s_lrck;
      end
   endfunction

   function automatic int stream_errors();
      int errs = 0;
      for (int j = 0; j < got_q.size() / 64; j++) begin
         logic [15:0] h;
         if (j >= exp_q.size()) begin
            errs++;
         end else begin
            h = exp_q[j];
            for (int p = 0; p < 64; p++) begin
               int   slot = p % 32;
               logic lr = (p >= 32);
               logic sd = (slot >= 1 && slot <= 16) ? h[16 - slot] : 1'b0;
               if (got_q[64 * j + p] !== {lr, sd}) errs++;
            end
         end
      end
      return errs;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      mon_step();
      @(negedge clk);
   endtask

   task automatic drive(input logic ce, input logic [17:0] a);
      ce_1m = ce;
      audio_in = a;
      tick();
   endtask

   task automatic reset_dut();
      reset = 1'b1; ce_1m = 1'b0; audio_in = '0;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   function automatic logic [17:0] rand_audio();
      case ($urandom_range(0, 3))
         0:       return 18'h00000;
         1:       return 18'h3FFFF;
         default: return 18'($urandom_range(0, 18'h3FFFF));
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1; ce_1m = 1'b1; audio_in = 18'h3FFFF;
      repeat (4) tick();
      n_vec++;
      if ({sample_out, sample_valid} !== 17'h0) begin
         n_bad++; $display("FAIL reset_sample: got %h/%b, expected 0000/0", sample_out, sample_valid);
      end
      n_vec++;
      if ({i2s_bclk, i2s_lrck, i2s_sdata} !== 3'b000) begin
         n_bad++; $display("FAIL reset_i2s: got %b, expected 000", {i2s_bclk, i2s_lrck, i2s_sdata});
      end
      n_vec++;
      if ({overflow, underflow} !== 2'b00) begin
         n_bad++; $display("FAIL reset_flags: got %b, expected 00", {overflow, underflow});
      end
      n_vec++;
      if ({sample_out_b, sample_valid_b, i2s_bclk_b, overflow_b} !== 19'h0) begin
         n_bad++; $display("FAIL reset_dut_b: got %h, expected 0", {sample_out_b, sample_valid_b, i2s_bclk_b, overflow_b});
      end
      ce_1m = 1'b0;
   endtask

   task automatic test_decimate(input string name, input logic [17:0] a0, input logic [17:0] a1,
                                input logic [15:0] expv);
      int early = 0;
      reset_dut();
      for (int k = 0; k < 32; k++) begin
         drive(1'b1, (k % 2 == 1) ? a1 : a0);
         if (k < 31 && sample_valid !== 1'b0) early++;
      end
      n_vec++;
      if (early !== 0) begin
         n_bad++; $display("FAIL %s_early_valid: got %0d pulses, expected 0", name, early);
      end
      n_vec++;
      if (sample_valid !== 1'b1 || sample_out !== expv) begin
         n_bad++; $display("FAIL %s_sample: got %b/%h, expected 1/%h", name, sample_valid, sample_out, expv);
      end
      drive(1'b0, '0);
      n_vec++;
      if (sample_valid !== 1'b0 || sample_out !== expv) begin
         n_bad++; $display("FAIL %s_hold: got %b/%h, expected 0/%h", name, sample_valid, sample_out, expv);
      end
   endtask

   task automatic test_idle_underflow();
      int sd_high = 0;
      reset_dut();
      for (int i = 1; i <= 2 * FRAME + 8; i++) begin
         drive(1'b0, rand_audio());
         if (i2s_sdata !== 1'b0) sd_high++;
         if (i == FRAME - 1) begin
            n_vec++;
            if (underflow !== 1'b0) begin
               n_bad++; $display("FAIL idle_unf_early: got %b, expected 0", underflow);
            end
         end
         if (i == FRAME) begin
            n_vec++;
            if (underflow !== 1'b1) begin
               n_bad++; $display("FAIL idle_unf_set: got %b, expected 1", underflow);
            end
         end
      end
      n_vec++;
      if (sd_high !== 0 || overflow !== 1'b0) begin
         n_bad++; $display("FAIL idle_quiet: got %0d sdata-high cycles, ovf %b, expected 0, 0", sd_high, overflow);
      end
      n_vec++;
      if (got_q.size() < 128 || stream_errors() !== 0) begin
         n_bad++; $display("FAIL idle_stream: got %0d bits, %0d errors, expected >=128, 0", got_q.size(), stream_errors());
      end
      n_vec++;
      if (bclk_bad !== 0 || sd_bad !== 0) begin
         n_bad++; $display("FAIL idle_timing: got bclk_bad %0d sd_bad %0d, expected 0 0", bclk_bad, sd_bad);
      end
   endtask

   task automatic test_a5c3_frame();
      logic [31:0] exp_half, gl, gr;
      logic [63:0] lrw, f0;
      exp_half = {1'b0, 16'hA5C3, 15'h0000};
      gl = '0; gr = '0; lrw = '0; f0 = '0;
      reset_dut();
      for (int k = 0; k < 32; k++) drive(1'b1, 18'h0970C);
      while (m_t < 2 * FRAME + 4) drive(1'b0, '0);
      n_vec++;
      if (got_q.size() < 128) begin
         n_bad++; $display("FAIL a5c3_bits: got %0d bits, expected >=128", got_q.size());
      end else begin
         for (int p = 0; p < 64; p++) begin
            f0  = {f0[62:0], got_q[p][0]};
            lrw = {lrw[62:0], got_q[64 + p][1]};
         end
         for (int p = 0; p < 32; p++) begin
            gl = {gl[30:0], got_q[64 + p][0]};
            gr = {gr[30:0], got_q[96 + p][0]};
         end
         n_vec++;
         if (gl !== exp_half) begin
            n_bad++; $display("FAIL a5c3_left: got %h, expected %h", gl, exp_half);
         end
         n_vec++;
         if (gr !== exp_half) begin
            n_bad++; $display("FAIL a5c3_right: got %h, expected %h", gr, exp_half);
         end
         n_vec++;
         if (lrw !== 64'h00000000_FFFFFFFF) begin
            n_bad++; $display("FAIL a5c3_lrck: got %h, expected 00000000ffffffff", lrw);
         end
         n_vec++;
         if (f0 !== 64'h0) begin
            n_bad++; $display("FAIL a5c3_frame0: got %h, expected 0", f0);
         end
      end
      n_vec++;
      if (bclk_bad !== 0 || sd_bad !== 0) begin
         n_bad++; $display("FAIL a5c3_timing: got bclk_bad %0d sd_bad %0d, expected 0 0", bclk_bad, sd_bad);
      end
   endtask

   task automatic test_random_stream();
      reset_dut();
      for (int i = 0; i < 3000; i++) begin
         if (i < 1200) drive($urandom_range(0, 7) == 0, rand_audio());
         else drive(1'($urandom_range(0, 1)), rand_audio());
         n_vec++;
         if ({sample_out, sample_valid, overflow, underflow} !== {m_sample, m_valid, m_ovf, m_unf}) begin
            n_bad++;
            $display("FAIL rand_cycle %0d: got %h/%b/%b/%b, expected %h/%b/%b/%b", i, sample_out, sample_valid,
                     overflow, underflow, m_sample, m_valid, m_ovf, m_unf);
         end
      end
      n_vec++;
      if (got_q.size() < 640 || stream_errors() !== 0) begin
         n_bad++; $display("FAIL rand_stream: got %0d bits, %0d errors, expected >=640, 0", got_q.size(), stream_errors());
      end
      n_vec++;
      if (bclk_bad !== 0 || sd_bad !== 0) begin
         n_bad++; $display("FAIL rand_timing: got bclk_bad %0d sd_bad %0d, expected 0 0", bclk_bad, sd_bad);
      end
   endtask

   task automatic test_fifo_order();
      reset_dut();
      for (int i = 0; i < 6 * FRAME + 4; i++) begin
         drive(i < 192, rand_audio());
         n_vec++;
         if ({sample_out, sample_valid, overflow, underflow} !== {m_sample, m_valid, m_ovf, m_unf}) begin
            n_bad++;
            $display("FAIL fifo_cycle %0d: got %h/%b/%b/%b, expected %h/%b/%b/%b", i, sample_out, sample_valid,
                     overflow, underflow, m_sample, m_valid, m_ovf, m_unf);
         end
      end
      n_vec++;
      if (overflow !== 1'b1) begin
         n_bad++; $display("FAIL fifo_ovf: got %b, expected 1", overflow);
      end
      n_vec++;
      if (got_q.size() < 6 * 64 || stream_errors() !== 0) begin
         n_bad++; $display("FAIL fifo_stream: got %0d bits, %0d errors, expected >=384, 0", got_q.size(), stream_errors());
      end
   endtask

   task automatic test_reset_mid_frame();
      reset_dut();
      while (m_t < 40 * 2 * BD + 2) drive(1'b1, rand_audio());
      n_vec++;
      if (overflow !== m_ovf) begin
         n_bad++; $display("FAIL mid_pre_ovf: got %b, expected %b", overflow, m_ovf);
      end
      reset = 1'b1;
      drive(1'b0, '0);
      n_vec++;
      if ({sample_out, sample_valid, i2s_bclk, i2s_lrck, i2s_sdata, overflow, underflow} !== 22'h0) begin
         n_bad++;
         $display("FAIL mid_reset_outputs: got %h, expected 0",
                  {sample_out, sample_valid, i2s_bclk, i2s_lrck, i2s_sdata, overflow, underflow});
      end
      reset = 1'b0;
      for (int i = 0; i < 2 * FRAME + 4; i++) drive(1'b0, '0);
      n_vec++;
      if (got_q.size() < 128 || got_q[0] !== 2'b00 || stream_errors() !== 0) begin
         n_bad++; $display("FAIL mid_restart_stream: got %0d bits, %0d errors, expected >=128, 0", got_q.size(), stream_errors());
      end
      n_vec++;
      if ({overflow, underflow} !== 2'b01) begin
         n_bad++; $display("FAIL mid_restart_flags: got %b, expected 01", {overflow, underflow});
      end
   endtask

   task automatic test_overflow_b();
      logic [17:0] s[$];
      logic [17:0] a;
      logic        exp_valid, exp_ovf;
      logic [15:0] exp_s;
      reset_dut();
      for (int i = 0; i <= 13; i++) begin
         if (i >= 1) begin
            exp_valid = (i >= 2) && (i % 2 == 0);
            n_vec++;
            if (sample_valid_b !== exp_valid) begin
               n_bad++; $display("FAIL b_valid %0d: got %b, expected %b", i, sample_valid_b, exp_valid);
            end
            if (exp_valid) begin
               exp_s = 16'((int'(s[i-2]) + int'(s[i-1]) - 262144) >>> 3);
               n_vec++;
               if (sample_out_b !== exp_s) begin
                  n_bad++; $display("FAIL b_sample %0d: got %h, expected %h", i, sample_out_b, exp_s);
               end
            end
            exp_ovf = ((i - 1) / 2) >= 5;
            n_vec++;
            if (overflow_b !== exp_ovf) begin
               n_bad++; $display("FAIL b_overflow %0d: got %b, expected %b", i, overflow_b, exp_ovf);
            end
         end
         a = rand_audio();
         s.push_back(a);
         drive(1'b1, a);
      end
   endtask

   initial begin
      test_reset();
      test_decimate("const_30000", 18'h30000, 18'h30000, 16'h4000);
      test_decimate("alternate", 18'h00000, 18'h3FFFF, 16'hFFFF);
      test_decimate("full_scale", 18'h3FFFF, 18'h3FFFF, 16'h7FFF);
      test_decimate("zero_scale", 18'h00000, 18'h00000, 16'h8000);
      test_decimate("midpoint", 18'h20000, 18'h20000, 16'h0000);
      test_idle_underflow();
      test_a5c3_frame();
      test_random_stream();
      test_fifo_order();
      test_reset_mid_frame();
      test_overflow_b();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/sid_audio_i2s.md
SID_AUDIO_I2S -- requirements
Module: sid_audio_i2s

Interface
REQ-001 SHALL have parameter DECIM_LOG2, default 5, log2 of the decimation ratio (32 ce_1m samples per output sample).
REQ-002 SHALL have parameter BCLK_DIV, default 8, bit-clock half-period in clk cycles (legal range 1..255).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ce_1m  input  1  one-clk-wide enable marking a valid audio_in sample.
REQ-006 SHALL have port audio_in  input  18  unsigned offset-binary SID mixer output, midpoint 18'h20000.
REQ-007 SHALL have port sample_out  output  16  last decimated signed sample.
REQ-008 SHALL have port sample_valid  output  1  one-clk pulse when sample_out updates.
REQ-009 SHALL have port i2s_bclk  output  1  I2S bit clock.
REQ-010 SHALL have port i2s_lrck  output  1  I2S word select; 0 = left, 1 = right.
REQ-011 SHALL have port i2s_sdata  output  1  I2S serial data.
REQ-012 SHALL have port overflow  output  1  sticky flag; FIFO push refused.
REQ-013 SHALL have port underflow  output  1  sticky flag; frame started with FIFO empty.

Function
REQ-014 On each ce_1m, audio_in SHALL be converted to signed by inverting bit 17 and added to a signed accumulator of width 18+DECIM_LOG2.
REQ-015 A sample counter of DECIM_LOG2 bits SHALL increment on each ce_1m and wrap from all-ones to 0.
REQ-016 On the ce_1m where the counter is all-ones, the accumulator SHALL clear to 0 after including that sample.
REQ-017 One clk after that ce_1m, sample_valid SHALL pulse for one clk; sample_out SHALL be bits [17+DECIM_LOG2 : 2+DECIM_LOG2] of the completed sum (arithmetic mean, truncated to 16 bits).
REQ-018 ce_1m is ignored when low; no accumulation, no counting.
REQ-019 Each sample_valid SHALL push sample_out into a 4-entry FIFO.
REQ-020 Push while full without a same-cycle pop: sample dropped, FIFO unchanged, overflow set.
REQ-021 Push and pop in the same cycle while full: both SHALL succeed; overflow SHALL not be set.
REQ-022 A divider SHALL toggle i2s_bclk every BCLK_DIV clk cycles; i2s_bclk idles low after reset.
REQ-023 A 6-bit bit counter SHALL advance on each bclk falling edge; frame = 64 bclk periods, 32 per channel.
REQ-024 i2s_lrck SHALL be 0 for bit counts 0..31 and 1 for 32..63, changing on the bclk falling edge.
REQ-025 Standard I2S timing: data MSB SHALL appear on the falling edge one bclk after each lrck transition; 16 data bits MSB-first; remaining 15 bits of each half SHALL be 0.
REQ-026 Both channels SHALL carry the same 16-bit sample.
REQ-027 At bit count 63 falling edge (frame end), the FIFO SHALL be popped into the frame holding register if non-empty.
REQ-028 If empty at frame end, the holding register SHALL retain the previous sample and underflow SHALL be set.
REQ-029 i2s_sdata SHALL change only on bclk falling edges; it is stable across every rising edge.
REQ-030 overflow and underflow SHALL clear only on reset.

Reset
REQ-031 While reset is high: accumulator, sample counter, FIFO pointers and occupancy SHALL be 0.
REQ-032 While reset is high: holding register, sample_out, sample_valid, i2s_bclk, i2s_lrck, i2s_sdata, overflow and underflow SHALL be 0.
REQ-033 While reset is high: the divider and bit counter SHALL be 0.
REQ-034 Reset asserted mid-frame or mid-accumulation SHALL abandon partial state; on release the first output frame begins at bit count 0 carrying sample 0.

Verification
REQ-035 DECIM_LOG2=5: 32 ce_1m with audio_in=18'h30000 -> one sample_valid 1 clk after the 32nd ce; sample_out=16'h4000.
REQ-036 32 ce_1m alternating audio_in 18'h00000 / 18'h3FFFF -> sample_out=16'hFFFF (mean -0.5, truncated).
REQ-037 BCLK_DIV=2, FIFO holding 16'hA5C3 -> left and right halves each shift 1010010111000011 starting one bclk after the lrck edge, then 15 zeros; bclk period 4 clk.
REQ-038 Release reset, no ce_1m for 2 frames -> sdata all 0, underflow=1 after the first frame end, overflow=0.
REQ-039 BCLK_DIV=255, ce_1m every clk, DECIM_LOG2=1 -> FIFO fills; 5th push with no pop sets overflow; the first four samples emerge in order.
REQ-040 Assert reset at bit count 40 for 1 clk -> all outputs 0 next clk; flags cleared; the next frame starts lrck=0 with sample 0.
